// File: rtl/sr_pkg.sv
// Shared types and command decode for the SR flag register bank.
package sr_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    SET_DOM = 2'd1,
    RST_DOM = 2'd2,
    TOGGLE  = 2'd3
  } sr_mode_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SET  = 2'd1,
    RST  = 2'd2,
    BOTH = 2'd3
  } sr_cmd_e;

  function automatic sr_cmd_e sr_decode(input logic s, input logic r);
    case ({s, r})
      2'b10:   return SET;
      2'b01:   return RST;
      2'b11:   return BOTH;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/sr_register_bank_cell.sv
// One SR channel: stability filter, state flop, change pulse and sticky conflict flag.
module sr_cell
  import sr_pkg::*;
#(
  parameter int unsigned FILTER_LEN    = 1,
  parameter int unsigned CONFLICT_MODE = 0,
  parameter bit          RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic clr_status,
  output logic q,
  output logic qbar,
  output logic changed,
  output logic conflict,
  output logic both_fire_c
);

  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
  localparam sr_mode_e    MODE   = sr_mode_e'(CONFLICT_MODE[1:0]);

  sr_cmd_e             cmd_c;
  sr_cmd_e             last_cmd_q, last_cmd_d;
  logic [FCNT_W-1:0]   cnt_q, cnt_d;
  logic                q_q, q_d, qbar_q, qbar_d;
  logic                changed_q, changed_d, conflict_q, conflict_d;
  logic                fire_c;

  always_comb begin
    cmd_c      = sr_decode(s, r);
    last_cmd_d = last_cmd_q;
    cnt_d      = cnt_q;
    fire_c     = 1'b0;
    q_d        = q_q;

    // A command fires once, on the cycle its run length reaches FILTER_LEN
    if (!en) begin
      last_cmd_d = NONE;
      cnt_d      = '0;
    end else if ((cmd_c != last_cmd_q) || (cmd_c == NONE)) begin
      last_cmd_d = cmd_c;
      cnt_d      = (cmd_c == NONE) ? '0 : FCNT_W'(1);
      fire_c     = (cmd_c != NONE) && (FILTER_LEN == 1);
    end else begin
      if (cnt_q != FCNT_W'(FILTER_LEN)) cnt_d = cnt_q + FCNT_W'(1);
      fire_c = (cnt_q == FCNT_W'(FILTER_LEN - 1));
    end

    if (fire_c) begin
      case (cmd_c)
        SET: q_d = 1'b1;
        RST: q_d = 1'b0;
        BOTH: begin
          case (MODE)
            SET_DOM: q_d = 1'b1;
            RST_DOM: q_d = 1'b0;
            TOGGLE:  q_d = ~q_q;
            default: q_d = q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end

    both_fire_c = fire_c && (cmd_c == BOTH);
    qbar_d      = ~q_d;
    changed_d   = (q_d != q_q);
    conflict_d  = (conflict_q && !clr_status) || both_fire_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_cmd_q <= NONE;
      cnt_q      <= '0;
      q_q        <= RESET_VAL;
      qbar_q     <= ~RESET_VAL;
      changed_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      last_cmd_q <= last_cmd_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      qbar_q     <= qbar_d;
      changed_q  <= changed_d;
      conflict_q <= conflict_d;
    end
  end

  assign q        = q_q;
  assign qbar     = qbar_q;
  assign changed  = changed_q;
  assign conflict = conflict_q;

endmodule

// File: rtl/sr_register_bank.sv
// Bank of WIDTH filtered SR flag channels.
// Define SR_CONFLICT_CNT_EN to add the saturating conflict_cnt event counter.
module sr_register_bank
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned FILTER_LEN    = 1,
  parameter int unsigned CONFLICT_MODE = 0,
  parameter bit          RESET_VAL     = 1'b0,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_status,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] changed,
  output logic [WIDTH-1:0] conflict
`ifdef SR_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  logic [WIDTH-1:0] both_fire_c;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    sr_cell #(
      .FILTER_LEN   (FILTER_LEN),
      .CONFLICT_MODE(CONFLICT_MODE),
      .RESET_VAL    (RESET_VAL)
    ) u_cell (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .s          (s[i]),
      .r          (r[i]),
      .clr_status (clr_status),
      .q          (q[i]),
      .qbar       (qbar[i]),
      .changed    (changed[i]),
      .conflict   (conflict[i]),
      .both_fire_c(both_fire_c[i])
    );
  end

`ifdef SR_CONFLICT_CNT_EN
  localparam int unsigned      SUM_W   = CNT_W + $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] ccnt_q, ccnt_d;
  logic [SUM_W-1:0] pop_c, sum_c;

  // Popcount of this edge's conflicts added to the (optionally cleared) total, saturating
  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) pop_c = pop_c + SUM_W'(both_fire_c[i]);
    sum_c  = (clr_status ? '0 : SUM_W'(ccnt_q)) + pop_c;
    ccnt_d = (sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum_c);
  end

  always_ff @(posedge clk) begin
    if (reset) ccnt_q <= '0;
    else       ccnt_q <= ccnt_d;
  end

  assign conflict_cnt = ccnt_q;
`else
  logic unused_c;
  assign unused_c = ^{both_fire_c, 32'(CNT_W)};
`endif

endmodule
